alu_cmd_sequencer: RTL and testbench

- Initiator side of the 8-bit ALU gate-level datapath (NOR/AND/OR/etc. bit-slice banks).
- Accepts one command (opcode + two operands) over a valid/ready interface and drives the operands and opcode onto the combinational ALU.
- Waits a fixed settle time, captures the ALU result and returns it with a zero flag over a second valid/ready interface.
- Opcode-transparent: opcodes pass through unchanged to the ALU select lines. One command is in flight at a time.

---
 rtl/alu_cmd_sequencer.sv | 99 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer driving an 8-bit combinational gate-level ALU.
// Holds one command in flight, samples the ALU after a fixed settle time.
module alu_cmd_sequencer #(
   parameter int WIDTH  = 8,
   parameter int OPW    = 3,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OPW-1:0]   cmd_op,
   input  logic [WIDTH-1:0] cmd_A,
   input  logic [WIDTH-1:0] cmd_B,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_Y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_Y,
   output logic             rsp_zero,
   output logic             busy
);

   generate
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("alu_cmd_sequencer: SETTLE must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETL,
      RESP
   } state_t;

   state_t     state;
   logic [3:0] cnt;

   // cmd_ready rises on the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         alu_A     <= '0;
         alu_B     <= '0;
         alu_op    <= '0;
         rsp_Y     <= '0;
         rsp_zero  <= 1'b0;
         rsp_valid <= 1'b0;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  alu_A     <= cmd_A;
                  alu_B     <= cmd_B;
                  alu_op    <= cmd_op;
                  cnt       <= CNT_INIT;
                  state     <= SETL;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            SETL: begin
               if (cnt == 4'd0) begin
                  rsp_Y     <= alu_Y;
                  rsp_zero  <= (alu_Y == '0);
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b0;
               busy      <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer.
// Two instances: SETTLE=2 (main) and SETTLE=1 (short settle).
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_zero, busy;
   logic [2:0] cmd_op, alu_op;
   logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y;

   logic       cmd_valid_1, cmd_ready_1, rsp_valid_1, rsp_ready_1;
   logic       rsp_zero_1, busy_1;
   logic [2:0] cmd_op_1, alu_op_1;
   logic [7:0] cmd_a_1, cmd_b_1, alu_a_1, alu_b_1, alu_y_1, rsp_y_1;

   logic       y_force_en;
   logic [7:0] y_force;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] m_a, m_b;
   logic [2:0] m_op;

   function automatic logic [7:0] ref_alu(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
      case (op)
         3'd0:    return ~(a | b);
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return a ^ b;
         3'd4:    return a + b;
         3'd5:    return a - b;
         3'd6:    return ~(a & b);
         default: return ~a;
      endcase
   endfunction

   assign alu_y = y_force_en ? y_force : ref_alu(alu_op, alu_a, alu_b);

   alu_cmd_sequencer #(.WIDTH(8), .OPW(3), .SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_A(cmd_a), .cmd_B(cmd_b),
      .alu_A(alu_a), .alu_B(alu_b), .alu_op(alu_op), .alu_Y(alu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_Y(rsp_y), .rsp_zero(rsp_zero), .busy(busy)
   );

   alu_cmd_sequencer #(.WIDTH(8), .OPW(3), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
      .cmd_op(cmd_op_1), .cmd_A(cmd_a_1), .cmd_B(cmd_b_1),
      .alu_A(alu_a_1), .alu_B(alu_b_1), .alu_op(alu_op_1), .alu_Y(alu_y_1),
      .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
      .rsp_Y(rsp_y_1), .rsp_zero(rsp_zero_1), .busy(busy_1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [29:0] o0, o1;
      rst_n = 1'b0;
      #23;
      o0 = {alu_a, alu_b, alu_op, rsp_y, rsp_valid, rsp_zero, busy, cmd_ready};
      o1 = {alu_a_1, alu_b_1, alu_op_1, rsp_y_1, rsp_valid_1, rsp_zero_1,
            busy_1, cmd_ready_1};
      n_chk++;
      if (o0 !== '0) begin
         n_fail++;
         $display("FAIL reset_outs: got %h expected 0", o0);
      end
      n_chk++;
      if (o1 !== '0) begin
         n_fail++;
         $display("FAIL reset_outs_s1: got %h expected 0", o1);
      end
      rst_n = 1'b1;
      tick();
      n_chk++;
      if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_release: rdy/busy/vld got %b expected 100",
                  {cmd_ready, busy, rsp_valid});
      end
      n_chk++;
      if ({cmd_ready_1, busy_1} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_release_s1: rdy/busy got %b expected 10",
                  {cmd_ready_1, busy_1});
      end
      m_a = 8'h00; m_b = 8'h00; m_op = 3'd0;
   endtask

   task automatic test_nor_zero();
      cmd_a = 8'h0F; cmd_b = 8'hF0; cmd_op = 3'd0; cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      m_a = 8'h0F; m_b = 8'hF0; m_op = 3'd0;
      n_chk++;
      if ({alu_a, alu_b, alu_op} !== {m_a, m_b, m_op}) begin
         n_fail++;
         $display("FAIL nor_drive: got %h expected %h",
                  {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
      end
      n_chk++;
      if ({busy, cmd_ready, rsp_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL nor_accept_flags: got %b expected 100",
                  {busy, cmd_ready, rsp_valid});
      end
      tick();
      n_chk++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL nor_early_valid: got %b expected 0", rsp_valid);
      end
      tick();
      n_chk++;
      if ({rsp_valid, rsp_y, rsp_zero} !== {1'b1, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL nor_rsp: vld/y/z got %b/%h/%b expected 1/00/1",
                  rsp_valid, rsp_y, rsp_zero);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_chk++;
      if ({rsp_valid, cmd_ready, busy, rsp_y, rsp_zero} !==
          {1'b0, 1'b1, 1'b0, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL nor_handshake: vld/rdy/busy/y/z got %b/%b/%b/%h/%b",
                  rsp_valid, cmd_ready, busy, rsp_y, rsp_zero);
      end
   endtask

   task automatic test_nonzero_hold();
      cmd_a = 8'h00; cmd_b = 8'h0F; cmd_op = 3'd0; cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      tick();
      m_a = 8'h00; m_b = 8'h0F; m_op = 3'd0;
      // a second command stays presented and must be ignored
      cmd_a = 8'h5A; cmd_b = 8'hC3; cmd_op = 3'd3;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if ({rsp_valid, rsp_y, rsp_zero, cmd_ready} !==
             {1'b1, 8'hF0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_%0d: vld/y/z/rdy got %b/%h/%b/%b exp 1/f0/0/0",
                     i, rsp_valid, rsp_y, rsp_zero, cmd_ready);
         end
         n_chk++;
         if ({alu_a, alu_b, alu_op} !== {m_a, m_b, m_op}) begin
            n_fail++;
            $display("FAIL hold_alu_%0d: got %h expected %h", i,
                     {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
         end
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_chk++;
      if ({rsp_valid, rsp_y, cmd_ready} !== {1'b0, 8'hF0, 1'b1}) begin
         n_fail++;
         $display("FAIL hold_release: vld/y/rdy got %b/%h/%b exp 0/f0/1",
                  rsp_valid, rsp_y, cmd_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] qa [3];
      logic [7:0] qb [3];
      logic [2:0] qo [3];
      logic [7:0] ey;
      for (int i = 0; i < 3; i++) begin
         qa[i] = 8'($urandom);
         qb[i] = 8'($urandom);
         qo[i] = 3'($urandom);
      end
      rsp_ready = 1'b1;
      // c = edges since the first command was presented
      for (int c = 0; c <= 12; c++) begin
         if (c % 4 == 1) begin
            m_a = qa[c/4]; m_b = qb[c/4]; m_op = qo[c/4];
         end
         n_chk++;
         if (cmd_ready !== (c % 4 == 0) || rsp_valid !== (c % 4 == 3)) begin
            n_fail++;
            $display("FAIL b2b_c%0d: rdy/vld got %b/%b expected %b/%b", c,
                     cmd_ready, rsp_valid, c % 4 == 0, c % 4 == 3);
         end
         n_chk++;
         if ({alu_a, alu_b, alu_op} !== {m_a, m_b, m_op}) begin
            n_fail++;
            $display("FAIL b2b_alu_c%0d: got %h expected %h", c,
                     {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
         end
         if (c % 4 == 3) begin
            ey = ref_alu(qo[c/4], qa[c/4], qb[c/4]);
            n_chk++;
            if ({rsp_y, rsp_zero} !== {ey, ey == 8'h00}) begin
               n_fail++;
               $display("FAIL b2b_rsp%0d: y/z got %h/%b expected %h/%b",
                        c / 4, rsp_y, rsp_zero, ey, ey == 8'h00);
            end
         end
         if (c / 4 < 3) begin
            cmd_valid = 1'b1;
            cmd_a = qa[c/4]; cmd_b = qb[c/4]; cmd_op = qo[c/4];
         end else begin
            cmd_valid = 1'b0;
         end
         if (c < 12) tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
   endtask

   task automatic test_settle_sample();
      logic [7:0] vals [2];
      y_force_en = 1'b1;
      y_force = 8'h11;
      cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 3'd2; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      m_a = 8'h12; m_b = 8'h34; m_op = 3'd2;
      tick();
      y_force = 8'hAA;
      n_chk++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL settle2_early: vld got %b expected 0", rsp_valid);
      end
      tick();
      y_force = 8'h55;
      n_chk++;
      if ({rsp_valid, rsp_y, rsp_zero} !== {1'b1, 8'hAA, 1'b0}) begin
         n_fail++;
         $display("FAIL settle2_sample: vld/y/z got %b/%h/%b expected 1/aa/0",
                  rsp_valid, rsp_y, rsp_zero);
      end
      tick();
      n_chk++;
      if (rsp_y !== 8'hAA) begin
         n_fail++;
         $display("FAIL settle2_late: y got %h expected aa", rsp_y);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      y_force_en = 1'b0;

      vals[0] = 8'hAA;
      vals[1] = 8'h00;
      rsp_ready_1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         alu_y_1 = 8'h11;
         cmd_a_1 = 8'($urandom); cmd_b_1 = 8'($urandom); cmd_op_1 = 3'd1;
         cmd_valid_1 = 1'b1;
         tick();
         cmd_valid_1 = 1'b0;
         alu_y_1 = vals[i];
         n_chk++;
         if ({rsp_valid_1, busy_1, alu_a_1} !== {1'b0, 1'b1, cmd_a_1}) begin
            n_fail++;
            $display("FAIL settle1_accept%0d: vld/busy/a got %b/%b/%h", i,
                     rsp_valid_1, busy_1, alu_a_1);
         end
         tick();
         alu_y_1 = 8'h55;
         n_chk++;
         if ({rsp_valid_1, rsp_y_1, rsp_zero_1} !==
             {1'b1, vals[i], vals[i] == 8'h00}) begin
            n_fail++;
            $display("FAIL settle1_sample%0d: vld/y/z got %b/%h/%b exp 1/%h/%b",
                     i, rsp_valid_1, rsp_y_1, rsp_zero_1, vals[i],
                     vals[i] == 8'h00);
         end
         rsp_ready_1 = 1'b1;
         tick();
         rsp_ready_1 = 1'b0;
      end
   endtask

   task automatic test_abort();
      logic [29:0] o0;
      logic [7:0]  ey;
      cmd_a = 8'h0F; cmd_b = 8'h0F; cmd_op = 3'd1; cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      o0 = {alu_a, alu_b, alu_op, rsp_y, rsp_valid, rsp_zero, busy, cmd_ready};
      n_chk++;
      if (o0 !== '0) begin
         n_fail++;
         $display("FAIL abort_async: got %h expected 0", o0);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_rsp%0d: vld got %b expected 0", i,
                     rsp_valid);
         end
      end
      #2;
      rst_n = 1'b1;
      m_a = 8'h00; m_b = 8'h00; m_op = 3'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_idle%0d: vld/rdy/busy got %b exp 010", i,
                     {rsp_valid, cmd_ready, busy});
         end
      end
      cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 3'd4;
      ey = ref_alu(cmd_op, cmd_a, cmd_b);
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      n_chk++;
      if ({rsp_valid, rsp_y, rsp_zero} !== {1'b1, ey, ey == 8'h00}) begin
         n_fail++;
         $display("FAIL abort_next: vld/y/z got %b/%h/%b expected 1/%h/%b",
                  rsp_valid, rsp_y, rsp_zero, ey, ey == 8'h00);
      end
      m_a = cmd_a; m_b = cmd_b; m_op = cmd_op;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_random_ops();
      logic [7:0] a, b, ey;
      logic [2:0] op;
      logic       was;
      int         k, lat, hold;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         if (i % 5 == 0) b = a;
         ey = ref_alu(op, a, b);
         cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
         for (k = 0; k < 8; k++) begin
            was = cmd_ready;
            tick();
            if (was) break;
         end
         cmd_valid = 1'b0;
         n_chk++;
         if (k == 8) begin
            n_fail++;
            $display("FAIL rand%0d_accept: timeout, got 0 accepts expected 1",
                     i);
         end
         m_a = a; m_b = b; m_op = op;
         lat = 0;
         while (rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
         end
         n_chk++;
         if (lat != 2) begin
            n_fail++;
            $display("FAIL rand%0d_latency: got %0d expected 2", i, lat);
         end
         hold = int'($urandom_range(0, 3));
         repeat (hold) tick();
         n_chk++;
         if ({rsp_valid, rsp_y, rsp_zero, cmd_ready, busy} !==
             {1'b1, ey, ey == 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rand%0d_rsp: vld/y/z/rdy/busy got %b/%h/%b/%b/%b exp 1/%h/%b/0/1",
                     i, rsp_valid, rsp_y, rsp_zero, cmd_ready, busy, ey,
                     ey == 8'h00);
         end
         n_chk++;
         if ({alu_a, alu_b, alu_op} !== {m_a, m_b, m_op}) begin
            n_fail++;
            $display("FAIL rand%0d_alu: got %h expected %h", i,
                     {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
         end
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         n_chk++;
         if ({rsp_valid, cmd_ready, rsp_y} !== {1'b0, 1'b1, ey}) begin
            n_fail++;
            $display("FAIL rand%0d_done: vld/rdy/y got %b/%b/%h exp 0/1/%h",
                     i, rsp_valid, cmd_ready, rsp_y, ey);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
      rsp_ready = 1'b0;
      cmd_valid_1 = 1'b0; cmd_a_1 = '0; cmd_b_1 = '0; cmd_op_1 = '0;
      rsp_ready_1 = 1'b0; alu_y_1 = '0;
      y_force_en = 1'b0; y_force = '0;
      m_a = '0; m_b = '0; m_op = '0;
      test_reset();
      test_nor_zero();
      test_nonzero_hold();
      test_back_to_back();
      test_settle_sample();
      test_abort();
      test_random_ops();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
